// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   FETCH/DECODE/EXEC control FSM for the accumulator CPU. Each instruction
//   takes three cycles. LD and STO stay in EXEC until the data memory reports
//   ready.
//
//   Optional feature macro: CTRL_CALL_STACK_EN
//     When it is defined, CALL (01111) and RET (10000) drive the return-stack
//     strobes and track stack occupancy. When it is not defined, both opcodes
//     are illegal and the stack outputs are tied to 0.
//
// Ports
//   clock_in, reset_in         clock; synchronous active-high reset
//   op_code                    opcode field from the IR, sampled in DECODE
//   status_Z_in, status_N_in   zero / negative flags, evaluated in EXEC
//   mem_ready_in               data memory completes the access this cycle
//   branch_out                 PC loads the operand field
//   sel_A_out, sel_B_out       accumulator source / ALU operand B select
//   alu_op_out                 ALU function
//   *_wr_out                   register / memory write enables
//   *_reset_out                register resets, high while in RST
//   halted_out, illegal_op_out core stopped / sticky fault flag
//   stack_push_out, stack_pop_out, stack_ptr_out  return-stack control
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int DATA_WIDTH        = 11,
  parameter int STACK_DEPTH       = 8,
  localparam int OPW = INSTRUCTION_WIDTH - DATA_WIDTH,
  localparam int SPW = $clog2(STACK_DEPTH) + 1
) (
  input  logic           clock_in,
  input  logic           reset_in,
  input  logic [OPW-1:0] op_code,
  input  logic           status_Z_in,
  input  logic           status_N_in,
  input  logic           mem_ready_in,
  output logic           branch_out,
  output logic [1:0]     sel_A_out,
  output logic           sel_B_out,
  output logic [2:0]     alu_op_out,
  output logic           data_memory_wr_out,
  output logic           acc_wr_out,
  output logic           pc_wr_out,
  output logic           status_wr_out,
  output logic           ir_wr_out,
  output logic           acc_reset_out,
  output logic           pc_reset_out,
  output logic           status_reset_out,
  output logic           ir_reset_out,
  output logic           halted_out,
  output logic           illegal_op_out,
  output logic           stack_push_out,
  output logic           stack_pop_out,
  output logic [SPW-1:0] stack_ptr_out
);

  localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
  localparam logic [OPW-1:0] OP_STO  = OPW'(1);
  localparam logic [OPW-1:0] OP_LD   = OPW'(2);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(7);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(8);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(9);
  localparam logic [OPW-1:0] OP_BGT  = OPW'(10);
  localparam logic [OPW-1:0] OP_BGE  = OPW'(11);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(12);
  localparam logic [OPW-1:0] OP_BLE  = OPW'(13);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(14);
`ifdef CTRL_CALL_STACK_EN
  localparam logic [OPW-1:0] OP_CALL = OPW'(15);
  localparam logic [OPW-1:0] OP_RET  = OPW'(16);
`endif
  localparam logic [OPW-1:0] OP_AND  = OPW'(17);
  localparam logic [OPW-1:0] OP_OR   = OPW'(18);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(19);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_rst_hold;   // keeps RST for one extra cycle after release
  logic [OPW-1:0] r_op;
  logic           r_illegal;
  logic           w_op_legal;
  logic           w_stack_fault;
  logic           w_set_illegal;

`ifdef CTRL_CALL_STACK_EN
  logic [SPW-1:0] r_stack_ptr;
  assign stack_ptr_out = r_stack_ptr;
  assign w_stack_fault = ((op_code == OP_CALL) && (r_stack_ptr == SPW'(STACK_DEPTH))) ||
                         ((op_code == OP_RET)  && (r_stack_ptr == '0));
`else
  assign stack_ptr_out = '0;
  assign w_stack_fault = 1'b0;
`endif

  assign illegal_op_out = r_illegal;

  always_comb begin
    w_op_legal = 1'b0;
    case (op_code)
      OP_STO, OP_LD, OP_LDI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
      OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP,
      OP_AND, OP_OR, OP_XOR: w_op_legal = 1'b1;
`ifdef CTRL_CALL_STACK_EN
      OP_CALL, OP_RET:       w_op_legal = 1'b1;
`endif
      default:               w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next             = r_state;
    w_set_illegal      = 1'b0;
    branch_out         = 1'b0;
    sel_A_out          = 2'b00;
    sel_B_out          = 1'b0;
    alu_op_out         = 3'b000;
    data_memory_wr_out = 1'b0;
    acc_wr_out         = 1'b0;
    pc_wr_out          = 1'b0;
    status_wr_out      = 1'b0;
    ir_wr_out          = 1'b0;
    acc_reset_out      = 1'b0;
    pc_reset_out       = 1'b0;
    status_reset_out   = 1'b0;
    ir_reset_out       = 1'b0;
    halted_out         = 1'b0;
    stack_push_out     = 1'b0;
    stack_pop_out      = 1'b0;

    case (r_state)
      S_RST: begin
        acc_reset_out    = 1'b1;
        pc_reset_out     = 1'b1;
        status_reset_out = 1'b1;
        ir_reset_out     = 1'b1;
        w_next           = r_rst_hold ? S_RST : S_FETCH;
      end
      S_FETCH: begin
        ir_wr_out = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        if (op_code == OP_HLT) begin
          w_next = S_HALT;
        end else if (!w_op_legal || w_stack_fault) begin
          w_next        = S_HALT;
          w_set_illegal = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_wr_out = 1'b1;
        w_next    = S_FETCH;
        case (r_op)
          OP_STO: begin
            data_memory_wr_out = 1'b1;
            if (!mem_ready_in) begin
              pc_wr_out = 1'b0;
              w_next    = S_EXEC;
            end
          end
          OP_LD: begin
            acc_wr_out = mem_ready_in;
            if (!mem_ready_in) begin
              pc_wr_out = 1'b0;
              w_next    = S_EXEC;
            end
          end
          OP_LDI: begin
            acc_wr_out = 1'b1;
            sel_A_out  = 2'b01;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            sel_A_out     = 2'b10;
            sel_B_out     = (r_op == OP_ADDI) || (r_op == OP_SUBI);
            alu_op_out    = ((r_op == OP_SUB) || (r_op == OP_SUBI)) ? 3'b001 : 3'b000;
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_AND, OP_OR, OP_XOR: begin
            sel_A_out     = 2'b10;
            alu_op_out    = (r_op == OP_AND) ? 3'b010 :
                            (r_op == OP_OR)  ? 3'b011 : 3'b100;
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_BEQ: branch_out = status_Z_in;
          OP_BNE: branch_out = !status_Z_in;
          OP_BGT: branch_out = !status_Z_in && !status_N_in;
          OP_BGE: branch_out = !status_N_in;
          OP_BLT: branch_out = status_N_in;
          OP_BLE: branch_out = status_Z_in || status_N_in;
          OP_JMP: branch_out = 1'b1;
`ifdef CTRL_CALL_STACK_EN
          OP_CALL: begin
            stack_push_out = 1'b1;
            branch_out     = 1'b1;
          end
          OP_RET: stack_pop_out = 1'b1;
`endif
          default: ;
        endcase
      end
      S_HALT: halted_out = 1'b1;
      default: w_next = S_RST;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state    <= S_RST;
      r_rst_hold <= 1'b1;
      r_op       <= '0;
      r_illegal  <= 1'b0;
`ifdef CTRL_CALL_STACK_EN
      r_stack_ptr <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_RST) r_rst_hold <= 1'b0;
      if (r_state == S_DECODE) r_op <= op_code;
      if (w_set_illegal) r_illegal <= 1'b1;
`ifdef CTRL_CALL_STACK_EN
      if (r_state == S_EXEC) begin
        if (r_op == OP_CALL)     r_stack_ptr <= r_stack_ptr + SPW'(1);
        else if (r_op == OP_RET) r_stack_ptr <= r_stack_ptr - SPW'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  localparam int IW    = 16;
  localparam int DW    = 11;
  localparam int DEPTH = 8;
  localparam int OPW   = IW - DW;
  localparam int SPW   = $clog2(DEPTH) + 1;
`ifdef CTRL_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [OPW-1:0] op  = '0;
  logic           z   = 1'b0;
  logic           n   = 1'b0;
  logic           rdy = 1'b0;

  logic           branch_out, sel_B_out;
  logic [1:0]     sel_A_out;
  logic [2:0]     alu_op_out;
  logic           dmw, accw, pcw, stw, irw, accr, pcr, str, irr;
  logic           halted, ill, push, pop;
  logic [SPW-1:0] ptr;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .INSTRUCTION_WIDTH(IW),
    .DATA_WIDTH(DW),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .op_code(op),
    .status_Z_in(z),
    .status_N_in(n),
    .mem_ready_in(rdy),
    .branch_out(branch_out),
    .sel_A_out(sel_A_out),
    .sel_B_out(sel_B_out),
    .alu_op_out(alu_op_out),
    .data_memory_wr_out(dmw),
    .acc_wr_out(accw),
    .pc_wr_out(pcw),
    .status_wr_out(stw),
    .ir_wr_out(irw),
    .acc_reset_out(accr),
    .pc_reset_out(pcr),
    .status_reset_out(str),
    .ir_reset_out(irr),
    .halted_out(halted),
    .illegal_op_out(ill),
    .stack_push_out(push),
    .stack_pop_out(pop),
    .stack_ptr_out(ptr)
  );

  typedef struct packed {
    logic           branch;
    logic [1:0]     sel_a;
    logic           sel_b;
    logic [2:0]     alu;
    logic           dmw, accw, pcw, stw, irw;
    logic           accr, pcr, str, irr;
    logic           halted, ill, push, pop;
    logic [SPW-1:0] ptr;
  } outs_t;

  outs_t act;
  assign act = {branch_out, sel_A_out, sel_B_out, alu_op_out, dmw, accw, pcw, stw, irw,
                accr, pcr, str, irr, halted, ill, push, pop, ptr};

  int n_checks = 0;
  int n_pass   = 0;
  int m_ptr    = 0;
  bit m_ill    = 1'b0;

  function automatic outs_t base();
    outs_t o = '0;
    o.ptr = SPW'(m_ptr);
    o.ill = m_ill;
    return o;
  endfunction

  function automatic bit is_legal(int o);
    return (o >= 1 && o <= 14) || (o >= 17 && o <= 19) || (STK && (o == 15 || o == 16));
  endfunction

  function automatic bit stack_fault(int o);
    return STK && ((o == 15 && m_ptr == DEPTH) || (o == 16 && m_ptr == 0));
  endfunction

  // Expected EXEC-cycle outputs taken straight from the opcode table.
  function automatic outs_t exp_exec(int o, bit fz, bit fn, bit r);
    outs_t e = base();
    e.pcw = 1'b1;
    case (o)
      1:  begin e.dmw = 1'b1; e.pcw = r; end
      2:  begin e.accw = r; e.pcw = r; end
      3:  begin e.accw = 1'b1; e.sel_a = 2'd1; end
      4, 5, 6, 7: begin
        e.sel_a = 2'd2; e.sel_b = (o == 5 || o == 7); e.alu = (o >= 6) ? 3'd1 : 3'd0;
        e.accw = 1'b1; e.stw = 1'b1;
      end
      17, 18, 19: begin
        e.sel_a = 2'd2; e.alu = 3'(o - 15); e.accw = 1'b1; e.stw = 1'b1;
      end
      8:  e.branch = fz;
      9:  e.branch = !fz;
      10: e.branch = !fz && !fn;
      11: e.branch = !fn;
      12: e.branch = fn;
      13: e.branch = fz || fn;
      14: e.branch = 1'b1;
      15: begin e.push = 1'b1; e.branch = 1'b1; end
      16: e.pop = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic cmp(input string name, input outs_t e);
    @(negedge clk);
    n_checks++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, e, $time);
  endtask

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic jitter();
    op  = OPW'($urandom_range(0, 31));
    z   = 1'($urandom_range(0, 1));
    n   = 1'($urandom_range(0, 1));
    rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic release_reset();
    outs_t e;
    rst   = 1'b0;
    m_ptr = 0;
    m_ill = 1'b0;
    e = base();
    e.accr = 1'b1; e.pcr = 1'b1; e.str = 1'b1; e.irr = 1'b1;
    jitter();
    cmp("rst_release_1", e);
    adv();
    jitter();
    cmp("rst_release_2", e);
    adv();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jitter();
    adv();
    release_reset();
  endtask

  // One instruction: FETCH, DECODE, then EXEC (with stalls) or HALT.
  // pin_br >= 0 adds a hand-computed branch_out expectation.
  task automatic run_instr(input int o, input int stall, input bit abort,
                           input bit force_f, input bit fz, input bit fn,
                           input int pin_br, output bit halted_o);
    outs_t e;
    halted_o = 1'b0;
    jitter();
    e = base(); e.irw = 1'b1;
    cmp("fetch", e);
    adv();
    jitter();
    op = OPW'(o);
    cmp("decode", base());
    adv();
    if (o == 0 || !is_legal(o) || stack_fault(o)) begin
      if (o != 0) m_ill = 1'b1;
      repeat (2) begin
        jitter();
        e = base(); e.halted = 1'b1;
        cmp("halt", e);
        adv();
      end
      halted_o = 1'b1;
      return;
    end
    if (o == 1 || o == 2) begin
      for (int s = 0; s < stall; s++) begin
        jitter();
        rdy = 1'b0;
        cmp("exec_stall", exp_exec(o, z, n, 1'b0));
        adv();
      end
      jitter();
      rdy = 1'b1;
      if (abort) begin
        rst = 1'b1;
        cmp("exec_abort", exp_exec(o, z, n, 1'b1));
        adv();
        release_reset();
        return;
      end
      cmp("exec_commit", exp_exec(o, z, n, 1'b1));
      adv();
    end else begin
      jitter();
      if (force_f) begin z = fz; n = fn; end
      cmp("exec", exp_exec(o, z, n, rdy));
      if (o == 3) begin
        lit("ldi_sel_a", 8'(sel_A_out), 8'd1);
        lit("ldi_acc_wr", 8'(accw), 8'd1);
      end
      if (o == 19) lit("xor_alu_op", 8'(alu_op_out), 8'd4);
      if (pin_br >= 0) lit("branch_pin", 8'(branch_out), 8'(pin_br));
      adv();
      if (o == 15) m_ptr++;
      if (o == 16) m_ptr--;
    end
  endtask

  int pool[$] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19};

  initial begin
    bit h;
    int o, r, st;

    do_reset();

    // Directed sequences
    run_instr(3, 0, 0, 0, 0, 0, -1, h);
    run_instr(2, 3, 0, 0, 0, 0, -1, h);
    run_instr(1, 3, 0, 0, 0, 0, -1, h);
    for (int b = 8; b <= 14; b++)
      for (int f = 0; f < 4; f++)
        run_instr(b, 0, 0, 1, f[1], f[0], -1, h);
    run_instr(10, 0, 0, 1, 0, 0, 1, h);
    run_instr(10, 0, 0, 1, 1, 0, 0, h);
    run_instr(13, 0, 0, 1, 0, 1, 1, h);
    run_instr(8,  0, 0, 1, 1, 0, 1, h);
    run_instr(12, 0, 0, 1, 0, 0, 0, h);
    for (int a = 4; a <= 7; a++) run_instr(a, 0, 0, 0, 0, 0, -1, h);
    for (int a = 17; a <= 19; a++) run_instr(a, 0, 0, 0, 0, 0, -1, h);
    run_instr(0, 0, 0, 0, 0, 0, -1, h);
    do_reset();
    run_instr(31, 0, 0, 0, 0, 0, -1, h);
    do_reset();
    run_instr(3, 0, 0, 0, 0, 0, -1, h);
    run_instr(1, 2, 1, 0, 0, 0, -1, h);
    run_instr(2, 0, 0, 0, 0, 0, -1, h);
    run_instr(15, 0, 0, 0, 0, 0, -1, h);
    if (h) do_reset();
    run_instr(16, 0, 0, 0, 0, 0, -1, h);
    if (h) do_reset();

`ifdef CTRL_CALL_STACK_EN
    for (int c = 0; c < DEPTH; c++) run_instr(15, 0, 0, 0, 0, 0, -1, h);
    run_instr(15, 0, 0, 0, 0, 0, -1, h);
    do_reset();
    run_instr(16, 0, 0, 0, 0, 0, -1, h);
    do_reset();
`endif

    // Randomized program
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3)      o = 0;
      else if (r < 6) o = $urandom_range(20, 31);
      else            o = pool[$urandom_range(0, pool.size() - 1)];
      st = $urandom_range(0, 3);
      run_instr(o, st, ($urandom_range(0, 9) == 0), 0, 0, 0, -1, h);
      if (h) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
